eth_rx_header_writer: RTL and testbench

- Receive-side front end for the Ethernet CPU data memory.
- Accepts the byte stream of an arriving frame and packs the bytes big-endian into 32-bit words.
- Writes the first HDR_WORDS words of each frame into a ring of header slots in data memory through the memory's receiver write port, and tracks how many completed frames are waiting.
- Presents the oldest completed frame (slot address, byte length) to the CPU until the CPU acknowledges it.

---
 rtl/eth_rx_header_writer.sv | 232 +++++++++++++++++++++++
 tb/tb_eth_rx_header_writer.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_rx_header_writer.sv
// Receive front end: packs frame bytes big-endian into words, writes the first HDR_WORDS words
// of each frame into a ring of header slots and queues completed frames for the CPU.
// Define ETH_RX_DROP_STATS_EN to add saturating drop/error counters with a clear input.
module eth_rx_header_writer #(
    parameter int         HDR_WORDS = 4,
    parameter int         NSLOTS    = 4,
    parameter logic [9:0] BASE_ADDR = 10'h000
) (
    input  logic        clock,
    input  logic        resetN,
    input  logic [7:0]  rxByte,
    input  logic        rxValid,
    input  logic        rxSof,
    input  logic        rxEof,
    input  logic        rxErr,
    output logic [9:0]  receiverAddress,
    output logic [31:0] receiverData,
    output logic        receiverWrite,
    output logic        frameReady,
    output logic [9:0]  frameAddr,
    output logic [10:0] frameLen,
    input  logic        frameAck
`ifdef ETH_RX_DROP_STATS_EN
    ,
    input  logic        statsClear,
    output logic [15:0] dropCount,
    output logic [15:0] errCount
`endif
);

    localparam int SW  = (NSLOTS > 1) ? $clog2(NSLOTS) : 1;
    localparam int CW  = SW + 1;
    localparam int WIW = $clog2(HDR_WORDS + 1);
    localparam logic [WIW-1:0] HDR_LIMIT  = WIW'(HDR_WORDS);
    localparam logic [CW-1:0]  SLOTS_FULL = CW'(NSLOTS);

    typedef enum logic [1:0] {IDLE, RECV, FLUSH, DROP} state_t;

    function automatic logic [10:0] sat_len(input logic [10:0] v);
        return (v == 11'h7FF) ? v : v + 11'd1;
    endfunction

    function automatic logic [15:0] sat_stat(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    function automatic logic [9:0] slot_addr(input logic [SW-1:0] slot, input logic [WIW-1:0] idx);
        logic [31:0] a;
        a = 32'(BASE_ADDR) + 32'(slot) * 32'(HDR_WORDS) + 32'(idx);
        return a[9:0];
    endfunction

    // Lane 0 starts a fresh word, so earlier bytes never leak into a new word.
    function automatic logic [31:0] pack_byte(input logic [31:0] acc, input logic [1:0] lane,
                                              input logic [7:0] b);
        logic [31:0] r;
        case (lane)
            2'd0:    r = {b, 24'h0};
            2'd1:    r = {acc[31:24], b, 16'h0};
            2'd2:    r = {acc[31:16], b, 8'h0};
            default: r = {acc[31:8], b};
        endcase
        return r;
    endfunction

    state_t          state;
    logic [10:0]     byteCnt;
    logic [WIW-1:0]  wordIdx;
    logic [1:0]      lane;
    logic [31:0]     acc;
    logic            errHeld;
    logic [SW-1:0]   wrSlot;
    logic [SW-1:0]   rdSlot;
    logic [CW-1:0]   count;
    logic [10:0]     lenMem [NSLOTS];

    logic            vld_p1;
    logic [9:0]      wrAddr_p1;
    logic [31:0]     wrData_p1;

    logic [31:0]     accNext;
    logic [1:0]      laneNext;
    logic            hdrOpen;
    logic            full;
    logic            startFrame;
    logic            flushOnEof;
    logic            commit;
    logic            ackTake;
    logic [10:0]     commitLen;

    always_comb begin
        accNext    = pack_byte(acc, lane, rxByte);
        laneNext   = lane + 2'd1;
        hdrOpen    = (wordIdx < HDR_LIMIT);
        full       = (count == SLOTS_FULL);
        startFrame = rxValid && rxSof && ((state == IDLE && !full) || state == RECV);
        flushOnEof = (laneNext != 2'd0) && hdrOpen;
        ackTake    = frameAck && (count != '0);
        commit     = 1'b0;
        commitLen  = byteCnt;
        if (state == RECV && rxValid && !rxSof && rxEof && !flushOnEof && !rxErr) begin
            commit    = 1'b1;
            commitLen = sat_len(byteCnt);
        end else if (state == FLUSH && !errHeld) begin
            commit = 1'b1;
        end
    end

    // Stage p0 -> p1: byte accept, word assembly and registered memory write
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state     <= IDLE;
            byteCnt   <= '0;
            wordIdx   <= '0;
            lane      <= '0;
            acc       <= '0;
            errHeld   <= 1'b0;
            vld_p1    <= 1'b0;
            wrAddr_p1 <= '0;
            wrData_p1 <= '0;
        end else begin
            vld_p1 <= 1'b0;
            if (startFrame) begin
                // A SOF inside RECV abandons the old frame and reuses the same slot.
                byteCnt <= 11'd1;
                wordIdx <= '0;
                lane    <= 2'd1;
                acc     <= {rxByte, 24'h0};
                if (rxEof) begin
                    vld_p1    <= 1'b1;
                    wrAddr_p1 <= slot_addr(wrSlot, '0);
                    wrData_p1 <= {rxByte, 24'h0};
                    errHeld   <= rxErr;
                    state     <= FLUSH;
                end else begin
                    state <= RECV;
                end
            end else begin
                case (state)
                    IDLE: begin
                        if (rxValid && rxSof)
                            state <= rxEof ? IDLE : DROP;
                    end
                    RECV: begin
                        if (rxValid) begin
                            byteCnt <= sat_len(byteCnt);
                            acc     <= accNext;
                            lane    <= laneNext;
                            if (laneNext == 2'd0 && hdrOpen) begin
                                vld_p1    <= 1'b1;
                                wrAddr_p1 <= slot_addr(wrSlot, wordIdx);
                                wrData_p1 <= accNext;
                                wordIdx   <= wordIdx + WIW'(1);
                            end
                            if (rxEof) begin
                                if (flushOnEof) begin
                                    vld_p1    <= 1'b1;
                                    wrAddr_p1 <= slot_addr(wrSlot, wordIdx);
                                    wrData_p1 <= accNext;
                                    errHeld   <= rxErr;
                                    state     <= FLUSH;
                                end else begin
                                    state <= IDLE;
                                end
                            end
                        end
                    end
                    FLUSH: begin
                        state <= IDLE;
                    end
                    default: begin
                        if (rxValid && rxEof)
                            state <= IDLE;
                    end
                endcase
            end
        end
    end

    // Frame queue: commit pushes at wrSlot, acknowledge pops at rdSlot
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            wrSlot <= '0;
            rdSlot <= '0;
            count  <= '0;
            for (int i = 0; i < NSLOTS; i++)
                lenMem[i] <= '0;
        end else begin
            if (commit) begin
                lenMem[wrSlot] <= commitLen;
                wrSlot         <= wrSlot + SW'(1);
            end
            if (ackTake)
                rdSlot <= rdSlot + SW'(1);
            count <= count + CW'(commit) - CW'(ackTake);
        end
    end

    assign receiverWrite   = vld_p1;
    assign receiverAddress = wrAddr_p1;
    assign receiverData    = wrData_p1;
    assign frameReady      = (count != '0);
    assign frameAddr       = slot_addr(rdSlot, '0);
    assign frameLen        = lenMem[rdSlot];

`ifdef ETH_RX_DROP_STATS_EN
    logic dropEvent;
    logic errEvent;

    always_comb begin
        dropEvent = (state == IDLE) && rxValid && rxSof && full;
        errEvent  = (state == FLUSH && errHeld) ||
                    (state == RECV && rxValid && (rxSof || (rxEof && rxErr && !flushOnEof)));
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            dropCount <= '0;
            errCount  <= '0;
        end else if (statsClear) begin
            dropCount <= '0;
            errCount  <= '0;
        end else begin
            if (dropEvent)
                dropCount <= sat_stat(dropCount);
            if (errEvent)
                errCount <= sat_stat(errCount);
        end
    end
`endif

endmodule

// File: tb/tb_eth_rx_header_writer.sv
// Bench for eth_rx_header_writer: directed vector table, hand-written corner sequences and
// randomized frames checked against a frame-level ring model.
module tb_eth_rx_header_writer;

    localparam int         HDR_WORDS = 4;
    localparam int         NSLOTS    = 4;
    localparam logic [9:0] BASE_ADDR = 10'h000;

    logic        clock = 1'b0;
    logic        resetN;
    logic [7:0]  rxByte;
    logic        rxValid, rxSof, rxEof, rxErr, frameAck;
    logic [9:0]  receiverAddress;
    logic [31:0] receiverData;
    logic        receiverWrite;
    logic        frameReady;
    logic [9:0]  frameAddr;
    logic [10:0] frameLen;
`ifdef ETH_RX_DROP_STATS_EN
    logic        statsClear;
    logic [15:0] dropCount, errCount;
`endif

    eth_rx_header_writer #(
        .HDR_WORDS(HDR_WORDS), .NSLOTS(NSLOTS), .BASE_ADDR(BASE_ADDR)
    ) dut (
        .clock(clock), .resetN(resetN),
        .rxByte(rxByte), .rxValid(rxValid), .rxSof(rxSof), .rxEof(rxEof), .rxErr(rxErr),
        .receiverAddress(receiverAddress), .receiverData(receiverData),
        .receiverWrite(receiverWrite),
        .frameReady(frameReady), .frameAddr(frameAddr), .frameLen(frameLen),
        .frameAck(frameAck)
`ifdef ETH_RX_DROP_STATS_EN
        , .statsClear(statsClear), .dropCount(dropCount), .errCount(errCount)
`endif
    );

    typedef logic [7:0] bq_t[$];
    typedef struct { logic [9:0] addr; logic [31:0] data; int cycle; } wr_t;
    typedef struct {
        bit ackBefore; int start; int len; bit err;
        int nWr; logic [9:0] a0; logic [31:0] d0; logic [9:0] aN; logic [31:0] dN;
        bit ready; logic [9:0] fAddr; logic [10:0] fLen;
    } vec_t;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    wr_t  wrLog[$];
    wr_t  expQ[$];
    vec_t vecs[6];

    int   mCount, mWr, mRd;
    int   mLen[NSLOTS];

    always #4 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;
    always @(negedge clock)
        if (receiverWrite) wrLog.push_back('{receiverAddress, receiverData, cyc});

    initial begin
        #2000000;
        $display("FAIL watchdog time limit expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [7:0] b, input logic v, input logic sof, input logic eof,
                         input logic err, input logic ack);
        @(posedge clock);
        #1;
        rxByte = b; rxValid = v; rxSof = sof; rxEof = eof; rxErr = err; frameAck = ack;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(8'h00, 0, 0, 0, 0, 0);
    endtask

    task automatic pulse_ack();
        drive(8'h00, 0, 0, 0, 0, 1);
        idle(1);
    endtask

    // c4/cEof: cycle stamps at which the 4th byte / last byte are taken by the DUT.
    task automatic send_bytes(input bq_t b, input bit sofFirst, input bit eofLast, input bit err,
                              input bit ackLast, input bit gaps, output int c4, output int cEof);
        int last;
        c4 = -1; cEof = -1; last = b.size() - 1;
        for (int i = 0; i <= last; i++) begin
            if (gaps && i > 0 && $urandom_range(0, 3) == 0)
                drive(8'($urandom), 0, 0, 0, 0, 0);
            drive(b[i], 1, sofFirst && i == 0, eofLast && i == last,
                  err && eofLast && i == last, ackLast && i == last);
            if (i == 3) c4 = cyc + 1;
            if (i == last) cEof = cyc + 1;
        end
    endtask

    function automatic bq_t make_inc(input int start, input int len);
        bq_t q;
        for (int i = 0; i < len; i++) q.push_back(8'(start + i));
        return q;
    endfunction

    task automatic do_reset();
        @(posedge clock);
        #1;
        rxByte = 0; rxValid = 0; rxSof = 0; rxEof = 0; rxErr = 0; frameAck = 0;
        resetN = 0;
        repeat (2) @(posedge clock);
        #1 resetN = 1;
    endtask

    // Header words a frame should leave in its slot: 4-byte big-endian chunks, zero padded,
    // at most HDR_WORDS of them; an abandoned frame only leaves its complete words.
    function automatic void add_exp(input bq_t b, input int slot, input bit complete);
        int nw;
        nw = complete ? (b.size() + 3) / 4 : b.size() / 4;
        if (nw > HDR_WORDS) nw = HDR_WORDS;
        for (int w = 0; w < nw; w++) begin
            logic [31:0] d;
            d = 32'h0;
            for (int j = 0; j < 4; j++)
                if (4 * w + j < b.size()) d[31 - 8 * j -: 8] = b[4 * w + j];
            expQ.push_back('{10'((int'(BASE_ADDR) + slot * HDR_WORDS + w) % 1024), d, 0});
        end
    endfunction

    task automatic rnd_frame(input int f);
        bq_t fr, pre, stray;
        int  len, k, c4, cE;
        bit  err, ab;
        if ($urandom_range(0, 2) == 0) begin
            if (mCount > 0) begin
                mRd = (mRd + 1) % NSLOTS;
                mCount--;
            end
            pulse_ack();
        end
        wrLog.delete();
        expQ.delete();
        if ($urandom_range(0, 5) == 0) begin
            k = $urandom_range(1, 5);
            for (int i = 0; i < k; i++) stray.push_back(8'($urandom));
            send_bytes(stray, 0, 1, 0, 0, 0, c4, cE);
            idle(2);
        end
        len = $urandom_range(1, 40);
        err = ($urandom_range(0, 7) == 0);
        ab  = ($urandom_range(0, 7) == 0);
        for (int i = 0; i < len; i++) fr.push_back(8'($urandom));
        if (ab) begin
            k = $urandom_range(1, 12);
            for (int i = 0; i < k; i++) pre.push_back(8'($urandom));
            send_bytes(pre, 1, 0, 0, 0, 1, c4, cE);
            if (mCount < NSLOTS) add_exp(pre, mWr, 0);
        end
        send_bytes(fr, 1, 1, err, 0, 1, c4, cE);
        if (mCount < NSLOTS) begin
            add_exp(fr, mWr, 1);
            if (!err) begin
                mLen[mWr] = (len > 2047) ? 2047 : len;
                mWr = (mWr + 1) % NSLOTS;
                mCount++;
            end
        end
        idle(3);
        check($sformatf("rnd%0d nwrites", f), wrLog.size(), expQ.size());
        if (wrLog.size() == expQ.size()) begin
            foreach (expQ[i]) begin
                check($sformatf("rnd%0d wr%0d addr", f, i), wrLog[i].addr, expQ[i].addr);
                check($sformatf("rnd%0d wr%0d data", f, i), wrLog[i].data, expQ[i].data);
            end
        end
        check($sformatf("rnd%0d frameReady", f), frameReady, mCount != 0);
        check($sformatf("rnd%0d frameAddr", f), frameAddr,
              10'((int'(BASE_ADDR) + mRd * HDR_WORDS) % 1024));
        if (mCount != 0)
            check($sformatf("rnd%0d frameLen", f), frameLen, mLen[mRd]);
    endtask

    initial begin
        int c4, cE;
        vecs[0] = '{1'b0, 'h00, 64, 1'b0, 4, 10'd0, 32'h00010203, 10'd3, 32'h0C0D0E0F, 1'b1, 10'd0, 11'd64};
        vecs[1] = '{1'b1, 'hAA, 6, 1'b0, 2, 10'd4, 32'hAAABACAD, 10'd5, 32'hAEAF0000, 1'b1, 10'd4, 11'd6};
        vecs[2] = '{1'b0, 'h10, 10, 1'b1, 3, 10'd8, 32'h10111213, 10'd10, 32'h18190000, 1'b1, 10'd4, 11'd6};
        vecs[3] = '{1'b1, 'h20, 3, 1'b0, 1, 10'd8, 32'h20212200, 10'd8, 32'h20212200, 1'b1, 10'd8, 11'd3};
        vecs[4] = '{1'b0, 'h55, 1, 1'b0, 1, 10'd12, 32'h55000000, 10'd12, 32'h55000000, 1'b1, 10'd8, 11'd3};
        vecs[5] = '{1'b1, 'h30, 20, 1'b0, 4, 10'd0, 32'h30313233, 10'd3, 32'h3C3D3E3F, 1'b1, 10'd12, 11'd1};

        resetN = 0; rxByte = 0; rxValid = 0; rxSof = 0; rxEof = 0; rxErr = 0; frameAck = 0;
`ifdef ETH_RX_DROP_STATS_EN
        statsClear = 0;
`endif
        repeat (3) @(posedge clock);
        #1;
        check("rst frameReady", frameReady, 0);
        check("rst frameAddr", frameAddr, 0);
        check("rst frameLen", frameLen, 0);
        check("rst receiverWrite", receiverWrite, 0);
        check("rst receiverAddress", receiverAddress, 0);
        check("rst receiverData", receiverData, 0);
        resetN = 1;
        idle(2);

        // 6-byte frame: full-word write and flush write timing
        wrLog.delete();
        send_bytes(make_inc('hAA, 6), 1, 1, 0, 0, 0, c4, cE);
        idle(3);
        check("f6 nwrites", wrLog.size(), 2);
        if (wrLog.size() == 2) begin
            check("f6 w0 addr", wrLog[0].addr, 0);
            check("f6 w0 data", wrLog[0].data, 32'hAAABACAD);
            check("f6 w0 cycle", wrLog[0].cycle, c4);
            check("f6 w1 addr", wrLog[1].addr, 1);
            check("f6 w1 data", wrLog[1].data, 32'hAEAF0000);
            check("f6 w1 cycle", wrLog[1].cycle, cE);
        end
        check("f6 frameReady", frameReady, 1);
        check("f6 frameAddr", frameAddr, 0);
        check("f6 frameLen", frameLen, 6);

        // Reset asserted mid-frame after 7 bytes
        send_bytes(make_inc('h80, 7), 1, 0, 0, 0, 0, c4, cE);
        @(posedge clock);
        #2;
        check("prerst receiverAddress", receiverAddress, 4);
        resetN = 0;
        #1;
        check("midrst frameReady", frameReady, 0);
        check("midrst frameLen", frameLen, 0);
        check("midrst frameAddr", frameAddr, 0);
        check("midrst receiverWrite", receiverWrite, 0);
        check("midrst receiverAddress", receiverAddress, 0);
        check("midrst receiverData", receiverData, 0);
        rxByte = 0; rxValid = 0; rxSof = 0; rxEof = 0; rxErr = 0; frameAck = 0;
        repeat (2) @(posedge clock);
        #1 resetN = 1;
        idle(2);

        // Directed vector table
        for (int k = 0; k < 6; k++) begin
            if (vecs[k].ackBefore) pulse_ack();
            idle(1);
            wrLog.delete();
            send_bytes(make_inc(vecs[k].start, vecs[k].len), 1, 1, vecs[k].err, 0, 0, c4, cE);
            idle(4);
            check($sformatf("vec%0d nwrites", k), wrLog.size(), vecs[k].nWr);
            if (wrLog.size() > 0) begin
                check($sformatf("vec%0d first addr", k), wrLog[0].addr, vecs[k].a0);
                check($sformatf("vec%0d first data", k), wrLog[0].data, vecs[k].d0);
                check($sformatf("vec%0d last addr", k), wrLog[wrLog.size() - 1].addr, vecs[k].aN);
                check($sformatf("vec%0d last data", k), wrLog[wrLog.size() - 1].data, vecs[k].dN);
            end
            check($sformatf("vec%0d frameReady", k), frameReady, vecs[k].ready);
            check($sformatf("vec%0d frameAddr", k), frameAddr, vecs[k].fAddr);
            check($sformatf("vec%0d frameLen", k), frameLen, vecs[k].fLen);
        end
`ifdef ETH_RX_DROP_STATS_EN
        check("stats errCount", errCount, 1);
        @(posedge clock);
        #1 statsClear = 1;
        @(posedge clock);
        #1 statsClear = 0;
        check("stats errCount cleared", errCount, 0);
`endif

        // Five frames into a 4-slot ring without acknowledge
        do_reset();
        wrLog.delete();
        for (int i = 0; i < 5; i++) begin
            send_bytes(make_inc(16 * i, 8), 1, 1, 0, 0, 0, c4, cE);
            idle(3);
        end
        check("full nwrites", wrLog.size(), 8);
        if (wrLog.size() == 8) begin
            check("full slot1 addr", wrLog[2].addr, 4);
            check("full slot2 addr", wrLog[4].addr, 8);
            check("full slot3 addr", wrLog[6].addr, 12);
            check("full slot3 data", wrLog[7].data, 32'h34353637);
        end
        check("full frameReady", frameReady, 1);
        check("full frameAddr", frameAddr, 0);
        check("full frameLen", frameLen, 8);
`ifdef ETH_RX_DROP_STATS_EN
        check("full dropCount", dropCount, 1);
`endif
        for (int i = 0; i < 4; i++) begin
            pulse_ack();
            idle(1);
            check($sformatf("drain%0d frameReady", i), frameReady, i < 3);
            check($sformatf("drain%0d frameAddr", i), frameAddr, (4 * (i + 1)) % 16);
        end
        pulse_ack();
        idle(1);
        check("empty ack frameReady", frameReady, 0);
        wrLog.delete();
        send_bytes(make_inc('hE0, 8), 1, 1, 0, 0, 0, c4, cE);
        idle(3);
        check("wrap nwrites", wrLog.size(), 2);
        if (wrLog.size() > 0) check("wrap addr", wrLog[0].addr, 0);
        check("wrap frameAddr", frameAddr, 0);
        check("wrap frameLen", frameLen, 8);

        // Commit and acknowledge in the same cycle with one frame queued
        do_reset();
        send_bytes(make_inc('h60, 8), 1, 1, 0, 0, 0, c4, cE);
        idle(3);
        send_bytes(make_inc('h70, 12), 1, 1, 0, 1, 0, c4, cE);
        idle(3);
        check("same frameReady", frameReady, 1);
        check("same frameAddr", frameAddr, 4);
        check("same frameLen", frameLen, 12);
        pulse_ack();
        idle(1);
        check("same count1 frameReady", frameReady, 0);

        // Length saturation
        wrLog.delete();
        send_bytes(make_inc(0, 2050), 1, 1, 0, 0, 0, c4, cE);
        idle(3);
        check("sat frameLen", frameLen, 2047);
        check("sat frameAddr", frameAddr, 8);
        check("sat nwrites", wrLog.size(), 4);

        // Randomized frames against the ring model
        do_reset();
        mCount = 0; mWr = 0; mRd = 0;
        foreach (mLen[i]) mLen[i] = 0;
        idle(2);
        for (int f = 0; f < 40; f++) rnd_frame(f);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
